id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the stall control mux. It captures the gated control bits plus the ID-stage operands, and presents them to the EX stage one cycle later.
- Performs immediate extension at capture using ExtOp, so EX receives a full-width immediate.
- Supports a downstream hold and a branch/jump flush, including a deferred flush that arrives during a hold. It also keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32, width of PC, register operands and extended immediate.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- hold_i  in  1  downstream (EX/MEM) stall; register keeps its contents.
- flush_i  in  1  branch/jump taken; next loaded entry is a bubble.
- bubble_i  in  1  hazard unit inserted a stall this cycle (control inputs already zeroed upstream).
- cnt_clr_i  in  1  clears the bubble counter.
- RegDst_i, ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, ExtOp_i  in  1 each  gated control bits.
- ALUOp_i  in  2  gated ALU op class.
- pc_i  in  DATA_W  PC+4 of the ID instruction.
- rs_data_i, rt_data_i  in  DATA_W  register file read data.
- imm_i  in  16  raw immediate field.
- rs_addr_i, rt_addr_i, rd_addr_i  in  5 each  register specifiers.
- RegDst_o, ALUSrc_o, MemToReg_o, RegWrite_o, MemWrite_o  out  1 each  registered controls.
- ALUOp_o  out  2  registered ALU op.
- pc_o, rs_data_o, rt_data_o, imm_o  out  DATA_W each  registered data; imm_o is extended.
- rs_addr_o, rt_addr_o, rd_addr_o  out  5 each  registered specifiers.
- valid_o  out  1  entry holds a real instruction.
- bubble_cnt_o  out  CNT_W  number of bubbles loaded since reset or clear.

Behaviour:
- Reset (rst_i=0 at an edge):
  - All outputs become 0, including valid_o and bubble_cnt_o.
  - pending_flush becomes 0.
  - Reset overrides every other input.
- Priority per edge: reset > hold > flush (applied or pending) > normal load.
- Hold (hold_i=1):
  - All output registers keep their values.
  - Bubble counter does not count.
  - If flush_i=1 during the hold, pending_flush is set to 1.
- Flush load (hold_i=0 and (flush_i=1 or pending_flush=1)):
  - All control outputs become 0, ALUOp_o becomes 2'b00, valid_o becomes 0.
  - Data and address outputs become 0.
  - pending_flush is cleared.
  - bubble_cnt increments.
- Normal load (hold_i=0, no flush):
  - All inputs are captured.
  - valid_o = ~bubble_i.
  - If bubble_i=1, bubble_cnt increments.
- Immediate extension at capture:
  - ExtOp_i=1 gives sign extension of imm_i[15] to DATA_W.
  - ExtOp_i=0 gives zero extension.
  - ExtOp is not forwarded to the output.
- Latency: exactly 1 cycle from capture edge to output for all fields. No combinational input-to-output path.
- Bubble counter:
  - Saturates at all-ones and does not wrap.
  - cnt_clr_i=1 forces the count to 0 at the edge and wins over a simultaneous increment.
  - cnt_clr_i is honoured during hold.
- Simultaneous flush_i and bubble_i with hold_i=0: treated as one flush, counted once.
- pending_flush is internal state only. Multiple flushes during one hold collapse into a single bubble.

Test Plan:
- Reset: drive rst_i=0 for 2 cycles with nonzero inputs -> all outputs 0, bubble_cnt_o=0. Release rst_i, load RegWrite_i=1, ALUOp_i=2'b10, rs_data_i=32'h1234 -> next cycle RegWrite_o=1, ALUOp_o=2'b10, rs_data_o=32'h1234, valid_o=1.
- Extension: imm_i=16'h8001 with ExtOp_i=1 -> imm_o=32'hFFFF8001. With ExtOp_i=0 -> imm_o=32'h00008001.
- Hold: load entry A, then hold_i=1 for 3 cycles while changing inputs to B -> outputs remain A for all 3 cycles; B appears one cycle after hold_i drops.
- Deferred flush: hold_i=1, pulse flush_i for 1 cycle mid-hold, release hold with valid inputs C -> first post-hold entry is a bubble (all controls 0, valid_o=0, bubble_cnt +1). C's fields never reach the outputs unless re-presented by upstream.
- Bubble counting: 5 cycles of bubble_i=1, then flush_i=1 together with bubble_i=1 -> bubble_cnt_o=6. Assert cnt_clr_i on the same edge as a further bubble -> bubble_cnt_o=0.
- Saturation: with CNT_W=4, insert 20 bubbles -> bubble_cnt_o=4'hF and stays there. Reset asserted while hold_i=1 and pending_flush=1 -> all outputs and pending state cleared; first load after reset is a normal entry.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures gated controls and ID operands, extends the
// immediate, and handles hold, immediate/deferred flush and bubble counting.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              bubble_i,
  input  logic              cnt_clr_i,
  input  logic              RegDst_i,
  input  logic              ALUSrc_i,
  input  logic              MemToReg_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic              ExtOp_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [15:0]       imm_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  output logic              RegDst_o,
  output logic              ALUSrc_o,
  output logic              MemToReg_o,
  output logic              RegWrite_o,
  output logic              MemWrite_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              pendingFlush_r;
  logic              flushNow_s;
  logic              countInc_s;
  logic [DATA_W-1:0] immExt_s;
  logic [CNT_W-1:0]  cntNext_s;

  function automatic logic [DATA_W-1:0] extendImm(input logic [15:0] imm, input logic signExt);
    if (signExt) begin
      extendImm = {{(DATA_W-16){imm[15]}}, imm};
    end else begin
      extendImm = {{(DATA_W-16){1'b0}}, imm};
    end
  endfunction

  // Next-state helpers: flush selection, bubble accounting and saturating count.
  always_comb begin
    flushNow_s = flush_i | pendingFlush_r;
    immExt_s   = extendImm(imm_i, ExtOp_i);
    if (hold_i) begin
      countInc_s = 1'b0;
    end else if (flushNow_s) begin
      countInc_s = 1'b1;
    end else begin
      countInc_s = bubble_i;
    end
    if (cnt_clr_i) begin
      cntNext_s = {CNT_W{1'b0}};
    end else if (countInc_s && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      cntNext_s = bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cntNext_s = bubble_cnt_o;
    end
  end

  // Pipeline register with reset > hold > flush > load priority.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      RegDst_o       <= 1'b0;
      ALUSrc_o       <= 1'b0;
      MemToReg_o     <= 1'b0;
      RegWrite_o     <= 1'b0;
      MemWrite_o     <= 1'b0;
      ALUOp_o        <= 2'b00;
      pc_o           <= {DATA_W{1'b0}};
      rs_data_o      <= {DATA_W{1'b0}};
      rt_data_o      <= {DATA_W{1'b0}};
      imm_o          <= {DATA_W{1'b0}};
      rs_addr_o      <= 5'd0;
      rt_addr_o      <= 5'd0;
      rd_addr_o      <= 5'd0;
      valid_o        <= 1'b0;
      bubble_cnt_o   <= {CNT_W{1'b0}};
      pendingFlush_r <= 1'b0;
    end else begin
      bubble_cnt_o <= cntNext_s;
      if (hold_i) begin
        // Contents frozen; any flush seen now is remembered for the next load.
        pendingFlush_r <= pendingFlush_r | flush_i;
      end else if (flushNow_s) begin
        RegDst_o       <= 1'b0;
        ALUSrc_o       <= 1'b0;
        MemToReg_o     <= 1'b0;
        RegWrite_o     <= 1'b0;
        MemWrite_o     <= 1'b0;
        ALUOp_o        <= 2'b00;
        pc_o           <= {DATA_W{1'b0}};
        rs_data_o      <= {DATA_W{1'b0}};
        rt_data_o      <= {DATA_W{1'b0}};
        imm_o          <= {DATA_W{1'b0}};
        rs_addr_o      <= 5'd0;
        rt_addr_o      <= 5'd0;
        rd_addr_o      <= 5'd0;
        valid_o        <= 1'b0;
        pendingFlush_r <= 1'b0;
      end else begin
        RegDst_o       <= RegDst_i;
        ALUSrc_o       <= ALUSrc_i;
        MemToReg_o     <= MemToReg_i;
        RegWrite_o     <= RegWrite_i;
        MemWrite_o     <= MemWrite_i;
        ALUOp_o        <= ALUOp_i;
        pc_o           <= pc_i;
        rs_data_o      <= rs_data_i;
        rt_data_o      <= rt_data_i;
        imm_o          <= immExt_s;
        rs_addr_o      <= rs_addr_i;
        rt_addr_o      <= rt_addr_i;
        rd_addr_o      <= rd_addr_i;
        valid_o        <= ~bubble_i;
        pendingFlush_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a cycle model pushes expected outputs, a
// monitor pops and compares; a 4-bit-counter instance exercises saturation.
module tb_id_ex_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hold, flush, bubble, cntClr;
  logic regDst, aluSrc, memToReg, regWrite, memWrite, extOp;
  logic [1:0]  aluOp;
  logic [31:0] pc, rsData, rtData;
  logic [15:0] imm;
  logic [4:0]  rsAddr, rtAddr, rdAddr;

  logic        oRegDst, oAluSrc, oMemToReg, oRegWrite, oMemWrite, oValid;
  logic [1:0]  oAluOp;
  logic [31:0] oPc, oRs, oRt, oImm;
  logic [4:0]  oRsA, oRtA, oRdA;
  logic [15:0] oCnt16;

  logic        sRegDst, sAluSrc, sMemToReg, sRegWrite, sMemWrite, sValid;
  logic [1:0]  sAluOp;
  logic [31:0] sPc, sRs, sRt, sImm;
  logic [4:0]  sRsA, sRtA, sRdA;
  logic [3:0]  oCnt4;

  id_ex_pipe #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .bubble_i(bubble),
    .cnt_clr_i(cntClr), .RegDst_i(regDst), .ALUSrc_i(aluSrc), .MemToReg_i(memToReg),
    .RegWrite_i(regWrite), .MemWrite_i(memWrite), .ExtOp_i(extOp), .ALUOp_i(aluOp),
    .pc_i(pc), .rs_data_i(rsData), .rt_data_i(rtData), .imm_i(imm),
    .rs_addr_i(rsAddr), .rt_addr_i(rtAddr), .rd_addr_i(rdAddr),
    .RegDst_o(oRegDst), .ALUSrc_o(oAluSrc), .MemToReg_o(oMemToReg),
    .RegWrite_o(oRegWrite), .MemWrite_o(oMemWrite), .ALUOp_o(oAluOp),
    .pc_o(oPc), .rs_data_o(oRs), .rt_data_o(oRt), .imm_o(oImm),
    .rs_addr_o(oRsA), .rt_addr_o(oRtA), .rd_addr_o(oRdA),
    .valid_o(oValid), .bubble_cnt_o(oCnt16)
  );

  id_ex_pipe #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .bubble_i(bubble),
    .cnt_clr_i(cntClr), .RegDst_i(regDst), .ALUSrc_i(aluSrc), .MemToReg_i(memToReg),
    .RegWrite_i(regWrite), .MemWrite_i(memWrite), .ExtOp_i(extOp), .ALUOp_i(aluOp),
    .pc_i(pc), .rs_data_i(rsData), .rt_data_i(rtData), .imm_i(imm),
    .rs_addr_i(rsAddr), .rt_addr_i(rtAddr), .rd_addr_i(rdAddr),
    .RegDst_o(sRegDst), .ALUSrc_o(sAluSrc), .MemToReg_o(sMemToReg),
    .RegWrite_o(sRegWrite), .MemWrite_o(sMemWrite), .ALUOp_o(sAluOp),
    .pc_o(sPc), .rs_data_o(sRs), .rt_data_o(sRt), .imm_o(sImm),
    .rs_addr_o(sRsA), .rt_addr_o(sRtA), .rd_addr_o(sRdA),
    .valid_o(sValid), .bubble_cnt_o(oCnt4)
  );

  typedef struct {
    logic [6:0]  ctrl;
    logic        valid;
    logic [31:0] pc, rs, rt, imm;
    logic [14:0] addr;
    int          cnt16;
    int          cnt4;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  bit   pend;
  int   testsRun = 0;
  int   testsFailed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one clock edge worth of behaviour, expressed as rules.
  task automatic tick();
    bit inc = 0;
    if (!rst) begin
      cur = '{default: '0};
      pend = 0;
    end else begin
      if (hold) begin
        pend = pend | flush;
      end else if (flush || pend) begin
        cur.ctrl = '0; cur.valid = 0; cur.pc = '0; cur.rs = '0; cur.rt = '0;
        cur.imm = '0; cur.addr = '0;
        pend = 0;
        inc = 1;
      end else begin
        cur.ctrl  = {regDst, aluSrc, memToReg, regWrite, memWrite, aluOp};
        cur.valid = !bubble;
        cur.pc = pc; cur.rs = rsData; cur.rt = rtData;
        cur.imm = (extOp && imm >= 16'h8000) ? (32'hFFFF0000 | imm) : {16'h0000, imm};
        cur.addr = {rsAddr, rtAddr, rdAddr};
        inc = bubble;
      end
      if (cntClr) begin
        cur.cnt16 = 0; cur.cnt4 = 0;
      end else if (inc) begin
        cur.cnt16 = (cur.cnt16 + 1 > 65535) ? 65535 : cur.cnt16 + 1;
        cur.cnt4  = (cur.cnt4 + 1 > 15) ? 15 : cur.cnt4 + 1;
      end
    end
    expQ.push_back(cur);
    @(negedge clk);
  endtask

  task automatic randData();
    {regDst, aluSrc, memToReg, regWrite, memWrite, extOp} = 6'($urandom);
    aluOp = 2'($urandom);
    pc = $urandom; rsData = $urandom; rtData = $urandom; imm = 16'($urandom);
    rsAddr = 5'($urandom); rtAddr = 5'($urandom); rdAddr = 5'($urandom);
  endtask

  task automatic idle();
    rst = 1'b1; hold = 1'b0; flush = 1'b0; bubble = 1'b0; cntClr = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("ctrl", 64'({oRegDst, oAluSrc, oMemToReg, oRegWrite, oMemWrite, oAluOp}), 64'(e.ctrl));
        check("valid", 64'(oValid), 64'(e.valid));
        check("pc", 64'(oPc), 64'(e.pc));
        check("rs_data", 64'(oRs), 64'(e.rs));
        check("rt_data", 64'(oRt), 64'(e.rt));
        check("imm", 64'(oImm), 64'(e.imm));
        check("addr", 64'({oRsA, oRtA, oRdA}), 64'(e.addr));
        check("cnt16", 64'(oCnt16), 64'(e.cnt16));
        check("cnt4", 64'(oCnt4), 64'(e.cnt4));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cur = '{default: '0};
    pend = 0;
    idle();
    randData();
    // Reset with nonzero inputs and a hold/flush on the second cycle.
    rst = 1'b0; tick();
    hold = 1'b1; flush = 1'b1; tick();
    idle();
    randData(); regWrite = 1'b1; aluOp = 2'b10; rsData = 32'h1234; tick();
    // Immediate extension.
    randData(); imm = 16'h8001; extOp = 1'b1; tick();
    randData(); imm = 16'h8001; extOp = 1'b0; tick();
    // Hold for three cycles while inputs change.
    randData(); tick();
    hold = 1'b1;
    repeat (3) begin randData(); tick(); end
    hold = 1'b0; randData(); tick();
    // Deferred flush during hold, then valid entry C presented twice.
    hold = 1'b1; randData(); tick();
    flush = 1'b1; tick();
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    hold = 1'b0; randData(); tick();
    tick();
    // Bubble counting, flush+bubble counted once, clear beats increment.
    cntClr = 1'b1; tick();
    cntClr = 1'b0; bubble = 1'b1;
    repeat (5) begin randData(); tick(); end
    flush = 1'b1; tick();
    flush = 1'b0; cntClr = 1'b1; tick();
    cntClr = 1'b0;
    // Saturation of the 4-bit counter.
    repeat (20) begin randData(); tick(); end
    bubble = 1'b0; tick();
    // Clear honoured during hold.
    hold = 1'b1; cntClr = 1'b1; tick();
    idle();
    // Reset while holding with a pending flush; next load must be normal.
    hold = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; rst = 1'b0; tick();
    idle(); randData(); tick();
    tick();
    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      randData();
      hold   = ($urandom_range(0, 99) < 25);
      flush  = ($urandom_range(0, 99) < 15);
      bubble = ($urandom_range(0, 99) < 30);
      cntClr = ($urandom_range(0, 99) < 3);
      rst    = ($urandom_range(0, 99) >= 2);
      tick();
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
